// File: rtl/spi_flash_resp.sv
// SPI mode-0 responder emulating the read side of a 25-series NOR flash.
// All SPI pins are oversampled in the clk domain; READ data comes from a byte-wide memory port.
module spi_flash_resp #(
  parameter logic [23:0] JEDEC_ID = 24'hEF4018,
  parameter logic [7:0]  STATUS1  = 8'h00
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        spi_cs_n,
  input  logic        spi_sclk,
  input  logic        spi_mosi,
  output logic        spi_miso,
  output logic        spi_miso_oe,
  output logic        mem_rd,
  output logic [23:0] mem_addr,
  input  logic [7:0]  mem_rdata,
  output logic        busy
);

  typedef enum logic [2:0] {
    S_IDLE, S_CMD, S_ADDR, S_DATA, S_ID, S_STAT, S_IGNORE
  } state_t;

  state_t      r_state, w_state_nxt;
  logic        r_cs_s1, r_cs_s2, r_cs_prev;
  logic        r_sclk_s1, r_sclk_s2, r_sclk_prev;
  logic        r_mosi_s1, r_mosi_s2;
  logic [2:0]  r_bitcnt;
  logic [1:0]  r_bytecnt;
  logic [22:0] r_shift;
  logic [7:0]  r_fetch;
  logic [7:0]  r_txsh;
  logic        r_miso, r_oe, r_mem_rd, r_rd_d;
  logic [23:0] r_mem_addr;

  logic        w_cs_high, w_cs_fall, w_rise, w_fall, w_bit_last;
  logic        w_out_state, w_shift_out, w_load;
  logic        w_rd_first, w_rd_next;
  logic [7:0]  w_cmd, w_byte;

  // CS sync resets low so a CS already low at reset release never looks like a fall
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cs_s1     <= 1'b0;
      r_cs_s2     <= 1'b0;
      r_cs_prev   <= 1'b0;
      r_sclk_s1   <= 1'b0;
      r_sclk_s2   <= 1'b0;
      r_sclk_prev <= 1'b0;
    end else begin
      r_cs_s1     <= spi_cs_n;
      r_cs_s2     <= r_cs_s1;
      r_cs_prev   <= r_cs_s2;
      r_sclk_s1   <= spi_sclk;
      r_sclk_s2   <= r_sclk_s1;
      r_sclk_prev <= r_sclk_s2;
    end
  end

  always_ff @(posedge clk) begin
    r_mosi_s1 <= spi_mosi;
    r_mosi_s2 <= r_mosi_s1;
  end

  assign w_cs_high   = r_cs_s2;
  assign w_cs_fall   = ~r_cs_s2 & r_cs_prev;
  assign w_rise      = r_sclk_s2 & ~r_sclk_prev;
  assign w_fall      = ~r_sclk_s2 & r_sclk_prev;
  assign w_bit_last  = (r_bitcnt == 3'd7);
  assign w_cmd       = {r_shift[6:0], r_mosi_s2};
  assign w_out_state = (r_state == S_DATA) || (r_state == S_ID) || (r_state == S_STAT);
  assign w_shift_out = w_fall & ~w_cs_high & w_out_state;
  assign w_load      = w_shift_out & (r_bitcnt == 3'd0);

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  // CS high is checked first so it wins over any SCLK edge seen in the same clk
  always_comb begin
    w_state_nxt = r_state;
    w_rd_first  = 1'b0;
    w_rd_next   = 1'b0;
    if (w_cs_high) begin
      w_state_nxt = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE: if (w_cs_fall) w_state_nxt = S_CMD;
        S_CMD: begin
          if (w_rise && w_bit_last) begin
            case (w_cmd)
              8'h03:   w_state_nxt = S_ADDR;
              8'h9F:   w_state_nxt = S_ID;
              8'h05:   w_state_nxt = S_STAT;
              default: w_state_nxt = S_IGNORE;
            endcase
          end
        end
        S_ADDR: begin
          if (w_rise && w_bit_last && (r_bytecnt == 2'd2)) begin
            w_state_nxt = S_DATA;
            w_rd_first  = 1'b1;
          end
        end
        S_DATA: if (w_rise && w_bit_last) w_rd_next = 1'b1;
        default: ;
      endcase
    end
  end

  always_comb begin
    w_byte = 8'h00;
    case (r_state)
      S_DATA: w_byte = r_fetch;
      S_STAT: w_byte = STATUS1;
      S_ID: begin
        case (r_bytecnt)
          2'd0:    w_byte = JEDEC_ID[23:16];
          2'd1:    w_byte = JEDEC_ID[15:8];
          2'd2:    w_byte = JEDEC_ID[7:0];
          default: w_byte = 8'h00;
        endcase
      end
      default: w_byte = 8'h00;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_bitcnt   <= 3'd0;
      r_bytecnt  <= 2'd0;
      r_miso     <= 1'b0;
      r_oe       <= 1'b0;
      r_mem_rd   <= 1'b0;
      r_rd_d     <= 1'b0;
      r_mem_addr <= 24'd0;
    end else begin
      r_mem_rd <= w_rd_first | w_rd_next;
      r_rd_d   <= r_mem_rd;
      if (w_cs_high) begin
        r_bitcnt  <= 3'd0;
        r_bytecnt <= 2'd0;
        r_miso    <= 1'b0;
        r_oe      <= 1'b0;
      end else begin
        if ((r_state == S_IDLE) && w_cs_fall) begin
          r_bitcnt  <= 3'd0;
          r_bytecnt <= 2'd0;
          r_miso    <= 1'b0;
          r_oe      <= 1'b1;
        end
        if (w_rise && (r_state != S_IDLE)) begin
          r_bitcnt <= r_bitcnt + 3'd1;
          if ((r_state == S_ADDR) && w_bit_last) r_bytecnt <= r_bytecnt + 2'd1;
        end
        // A fall with the bit counter at zero starts a new output byte
        if (w_load) begin
          r_miso <= w_byte[7];
          if ((r_state == S_ID) && (r_bytecnt != 2'd3)) r_bytecnt <= r_bytecnt + 2'd1;
        end else if (w_shift_out) begin
          r_miso <= r_txsh[7];
        end
      end
      if (w_rd_first)     r_mem_addr <= {r_shift, r_mosi_s2};
      else if (w_rd_next) r_mem_addr <= r_mem_addr + 24'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_rise) r_shift <= {r_shift[21:0], r_mosi_s2};
    if (r_rd_d) r_fetch <= mem_rdata;
    if (w_load)           r_txsh <= {w_byte[6:0], 1'b0};
    else if (w_shift_out) r_txsh <= {r_txsh[6:0], 1'b0};
  end

  assign spi_miso    = r_miso;
  assign spi_miso_oe = r_oe;
  assign mem_rd      = r_mem_rd;
  assign mem_addr    = r_mem_addr;
  assign busy        = (r_state != S_IDLE);

endmodule

// File: tb/tb_spi_flash_resp.sv
// Bench for spi_flash_resp: table of SPI transactions plus hand-written abort/reset sequences.
module tb_spi_flash_resp;

  logic        clk = 1'b0;
  logic        rst;
  logic        spi_cs_n, spi_sclk, spi_mosi;
  logic        spi_miso, spi_miso_oe, mem_rd, busy;
  logic [23:0] mem_addr;
  logic [7:0]  mem_rdata = 8'h00;

  int n_cmp = 0;
  int n_bad = 0;
  int n_rd  = 0;

  logic [7:0]  exp_q[$];
  logic [23:0] addr_q[$];

  typedef struct {
    logic [63:0] tx;
    int          n;
    logic [63:0] rx;
    logic [23:0] a0;
    int          nrd;
  } vec_t;

  vec_t vecs[5];

  spi_flash_resp #(.JEDEC_ID(24'hEF4018), .STATUS1(8'h5C)) dut (
    .clk(clk), .rst(rst), .spi_cs_n(spi_cs_n), .spi_sclk(spi_sclk), .spi_mosi(spi_mosi),
    .spi_miso(spi_miso), .spi_miso_oe(spi_miso_oe), .mem_rd(mem_rd), .mem_addr(mem_addr),
    .mem_rdata(mem_rdata), .busy(busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (mem_rd) mem_rdata <= mem_addr[7:0] ^ 8'hA5;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst === 1'b0 && mem_rd === 1'b1) begin
      n_rd++;
      if (addr_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL mem_rd_unexpected: got addr %h expected no read", mem_addr);
      end else begin
        check("mem_addr", {8'h00, mem_addr}, {8'h00, addr_q.pop_front()});
      end
    end
  end

  task automatic spi_bit(input logic b, output logic m, output logic oe_ok);
    spi_mosi = b;
    repeat (5) @(negedge clk);
    m     = spi_miso;
    oe_ok = (spi_miso_oe === 1'b1);
    spi_sclk = 1'b1;
    repeat (5) @(negedge clk);
    spi_sclk = 1'b0;
  endtask

  task automatic xfer(input logic [7:0] tx, output logic [7:0] rx, output logic oe_ok);
    logic m, ok;
    oe_ok = 1'b1;
    for (int i = 7; i >= 0; i--) begin
      spi_bit(tx[i], m, ok);
      rx[i] = m;
      if (!ok) oe_ok = 1'b0;
    end
  endtask

  task automatic cs_low();
    spi_cs_n = 1'b0;
    repeat (6) @(negedge clk);
  endtask

  task automatic cs_high(input logic check_oe);
    repeat (5) @(negedge clk);
    spi_cs_n = 1'b1;
    repeat (2) @(negedge clk);
    if (check_oe) check("oe_before_cs_sync", {31'd0, spi_miso_oe}, 32'd1);
    @(negedge clk);
    check("oe_after_cs_rise", {31'd0, spi_miso_oe}, 32'd0);
    check("busy_after_cs_rise", {31'd0, busy}, 32'd0);
    repeat (3) @(negedge clk);
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    logic [7:0] r;
    logic       ok, all_ok;
    all_ok = 1'b1;
    cs_low();
    for (int k = 0; k < v.nrd; k++) addr_q.push_back(v.a0 + 24'(k));
    for (int i = 0; i < v.n; i++) begin
      exp_q.push_back(v.rx[63-8*i -: 8]);
      xfer(v.tx[63-8*i -: 8], r, ok);
      if (!ok) all_ok = 1'b0;
      check($sformatf("vec%0d_byte%0d", idx, i), {24'd0, r}, {24'd0, exp_q.pop_front()});
    end
    check($sformatf("vec%0d_oe_low_during_xfer", idx), {31'd0, all_ok}, 32'd1);
    cs_high(1'b1);
    check($sformatf("vec%0d_reads_outstanding", idx), addr_q.size(), 32'd0);
    addr_q.delete();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] r;
    logic       m, ok;
    int         rd_before;

    vecs[0] = '{tx: 64'h9FFF_FFFF_FFFF_0000, n: 6, rx: 64'h00EF_4018_0000_0000, a0: 24'h0, nrd: 0};
    vecs[1] = '{tx: 64'h0300_0010_0000_0000, n: 8, rx: 64'h0000_0000_B5B4_B7B6, a0: 24'h000010, nrd: 5};
    vecs[2] = '{tx: 64'h03FF_FFFE_0000_0000, n: 7, rx: 64'h0000_0000_5B5A_A500, a0: 24'hFFFFFE, nrd: 4};
    vecs[3] = '{tx: 64'hAB00_0000_0000_0000, n: 3, rx: 64'h0000_0000_0000_0000, a0: 24'h0, nrd: 0};
    vecs[4] = '{tx: 64'h0500_0000_0000_0000, n: 3, rx: 64'h005C_5C00_0000_0000, a0: 24'h0, nrd: 0};

    rst = 1'b1; spi_cs_n = 1'b1; spi_sclk = 1'b0; spi_mosi = 1'b0;
    repeat (4) @(negedge clk);
    check("rst_miso", {31'd0, spi_miso}, 32'd0);
    check("rst_oe", {31'd0, spi_miso_oe}, 32'd0);
    check("rst_mem_rd", {31'd0, mem_rd}, 32'd0);
    check("rst_mem_addr", {8'd0, mem_addr}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    rst = 1'b0;
    repeat (4) @(negedge clk);

    for (int v = 0; v < 5; v++) run_vec(v, vecs[v]);

    // Abort: CS rises after 13 address bits, then a fresh JEDEC command
    rd_before = n_rd;
    cs_low();
    check("abort_busy", {31'd0, busy}, 32'd1);
    xfer(8'h03, r, ok);
    for (int i = 0; i < 13; i++) spi_bit(1'b1, m, ok);
    cs_high(1'b1);
    check("abort_no_mem_rd", n_rd, rd_before);
    run_vec(10, vecs[0]);

    // Reset asserted for one clk during DATA
    cs_low();
    addr_q.push_back(24'h000010);
    addr_q.push_back(24'h000011);
    xfer(8'h03, r, ok);
    xfer(8'h00, r, ok);
    xfer(8'h00, r, ok);
    xfer(8'h10, r, ok);
    xfer(8'h00, r, ok);
    check("rstmid_first_byte", {24'd0, r}, 32'h0000_00B5);
    for (int i = 0; i < 3; i++) spi_bit(1'b0, m, ok);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rstmid_busy", {31'd0, busy}, 32'd0);
    check("rstmid_oe", {31'd0, spi_miso_oe}, 32'd0);
    check("rstmid_mem_rd", {31'd0, mem_rd}, 32'd0);
    xfer(8'h9F, r, ok);
    repeat (6) @(negedge clk);
    check("rstmid_cs_low_not_cmd", {31'd0, busy}, 32'd0);
    check("rstmid_miso_quiet", {24'd0, r}, 32'd0);
    cs_high(1'b0);
    check("rstmid_reads_outstanding", addr_q.size(), 32'd0);
    addr_q.delete();
    run_vec(11, vecs[0]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
